fp_addsub_vseq: RTL

- Sequences one shared combinational fp_addsub unit across the elements of a vector operation.
- Accepts one command: length, element-wise or vector-scalar mode, add or subtract.
- Streams operand pairs out of the vector register file (VRF), feeds the FP unit, registers each result and writes it back by element index.
- Sits between the coprocessor instruction decoder and the FP add/sub datapath in the vector functional-unit cluster.

---
 rtl/fp_addsub_vseq.sv | 121 ++++++++++++
 1 files changed

// File: rtl/fp_addsub_vseq.sv
// Sequences a shared combinational FP add/sub unit across the elements of one vector command.
// Read -> capture -> FP result register -> write; one element per cycle, stall freezes every register.
module fp_addsub_vseq #(
  parameter int VLEN_MAX = 32,
  parameter int IDX_W    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [IDX_W:0]   cmd_len,
  input  logic             cmd_sub,
  input  logic             cmd_scalar,
  input  logic [31:0]      cmd_scalar_val,
  input  logic             stall,
  output logic             rd_en,
  output logic [IDX_W-1:0] rd_idx,
  input  logic [31:0]      rd_a,
  input  logic [31:0]      rd_b,
  output logic [31:0]      fu_a,
  output logic [31:0]      fu_b,
  output logic             fu_sub,
  input  logic [31:0]      fu_y,
  output logic             wr_en,
  output logic [IDX_W-1:0] wr_idx,
  output logic [31:0]      wr_data,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  localparam logic [IDX_W:0] LEN_MAX = (IDX_W+1)'(VLEN_MAX);

  state_t           state;
  logic [IDX_W:0]   len_q;
  logic [IDX_W:0]   issue_cnt;
  logic             sub_q;
  logic             scalar_q;
  logic [31:0]      scalar_val_q;
  logic             rd_pend;
  logic [IDX_W-1:0] rd_pend_idx;
  logic             op_valid;
  logic [31:0]      op_a;
  logic [31:0]      op_b;
  logic [IDX_W-1:0] op_idx;
  logic             wr_valid;
  logic [IDX_W:0]   len_clamped;

  assign len_clamped = (cmd_len > LEN_MAX) ? LEN_MAX : cmd_len;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == FIN) && !stall;
  assign rd_en     = (state == RUN) && !stall;
  assign rd_idx    = issue_cnt[IDX_W-1:0];
  assign wr_en     = wr_valid && !stall;
  assign fu_a      = op_a;
  assign fu_b      = op_b;
  assign fu_sub    = sub_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      len_q        <= '0;
      issue_cnt    <= '0;
      sub_q        <= 1'b0;
      scalar_q     <= 1'b0;
      scalar_val_q <= '0;
      rd_pend      <= 1'b0;
      rd_pend_idx  <= '0;
      op_valid     <= 1'b0;
      op_a         <= '0;
      op_b         <= '0;
      op_idx       <= '0;
      wr_valid     <= 1'b0;
      wr_idx       <= '0;
      wr_data      <= '0;
    end else begin
      // Accept ignores stall; every other state change waits for a free cycle.
      if (state == IDLE) begin
        if (cmd_valid) begin
          len_q        <= len_clamped;
          sub_q        <= cmd_sub;
          scalar_q     <= cmd_scalar;
          scalar_val_q <= cmd_scalar_val;
          issue_cnt    <= '0;
          state        <= (len_clamped == '0) ? FIN : RUN;
        end
      end else if (!stall) begin
        case (state)
          RUN: begin
            issue_cnt <= issue_cnt + 1'b1;
            if (issue_cnt == len_q - 1'b1) state <= DRAIN;
          end
          DRAIN: if (!rd_pend && !op_valid) state <= FIN;
          FIN:   state <= IDLE;
          default: state <= IDLE;
        endcase
      end

      // The VRF holds rd_a/rd_b until the next read, so a stalled capture loses nothing.
      if (!stall) begin
        rd_pend     <= rd_en;
        rd_pend_idx <= issue_cnt[IDX_W-1:0];
        op_valid    <= rd_pend;
        if (rd_pend) begin
          op_a   <= rd_a;
          op_b   <= scalar_q ? scalar_val_q : rd_b;
          op_idx <= rd_pend_idx;
        end
        wr_valid <= op_valid;
        if (op_valid) begin
          wr_data <= fu_y;
          wr_idx  <= op_idx;
        end
      end
    end
  end

endmodule
